fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side controller for the team's synchronous FIFO. It drives the FIFO's rd_en and captures the registered data_out, which arrives one cycle after rd_en.
- Presents the captured words on a valid/ready stream to downstream logic, at full throughput and with no word loss.
- Buffers words in a 2-entry skid buffer, so back-pressure never drops a word that has already left the FIFO.
- Also keeps a delivered-word counter and a sticky protocol-error flag for the verification environment.

Parameters:
FIFO_WIDTH, 16, width of FIFO data and stream data
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  allows new FIFO reads; when low, no new rd_en is issued and in-flight words still land
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after rd_en was accepted
fifo_underflow  input  1  FIFO underflow flag (registered in the FIFO)
fifo_rd_en  output  1  read request to the FIFO
m_data  output  FIFO_WIDTH  stream data (head of skid buffer)
m_valid  output  1  stream valid
m_ready  input  1  stream ready from downstream
rd_count  output  CNT_WIDTH  words delivered downstream (m_valid && m_ready), wraps modulo 2^CNT_WIDTH
busy  output  1  high when occupancy != 0 or inflight == 1
proto_err  output  1  sticky; set when fifo_underflow is seen high one cycle after this block asserted fifo_rd_en

Behaviour:
- Reset (rst high at a clock edge):
  - fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, busy=0, proto_err=0.
  - Skid buffer emptied; inflight cleared.
  - Reset mid-operation discards buffered and in-flight words; the FIFO word already popped is lost by design.
- fifo_rd_en is combinational:
  - Formula: en && !fifo_empty && ((occ + inflight) < 2 || pop).
  - occ is buffer occupancy (0..2); inflight is 1 if fifo_rd_en was high last cycle; pop = m_valid && m_ready.
  - Never asserted while rst is high.
  - Never asserted when fifo_empty=1, so this block never causes an underflow.
- Read latency:
  - fifo_rd_en high in cycle N -> fifo_data_out captured into the buffer at the end of cycle N+1.
  - Earliest m_valid is cycle N+2.
  - Steady state with m_ready held high and a non-empty FIFO: one word per cycle.
- Skid buffer:
  - 2-entry FIFO of FIFO_WIDTH bits, with pointers or a shift register.
  - m_data/m_valid come from the head entry; m_data holds stable while m_valid && !m_ready.
- Occupancy update per cycle:
  - occ_next = occ + inflight - pop.
  - occ + inflight never exceeds 2 (guaranteed by the rd_en rule). An implementation assertion on overflow of the buffer is required.
- Simultaneous push and pop on the same edge:
  - Both take effect.
  - At occ=1 the pushed word lands behind the head, or becomes the head if the old head pops.
  - Word order is strictly FIFO order.
- en deassert: no new rd_en from that cycle on. An in-flight word is still captured, and the buffer continues to drain.
- rd_count increments on every pop and wraps from 2^CNT_WIDTH-1 to 0.
- proto_err:
  - Set when inflight==1 && fifo_underflow==1.
  - Cleared only by rst.
  - Underflow pulses without a prior rd_en from this block are ignored.
- busy = (occ != 0) || inflight.

Test Plan:
1. Reset then idle:
   - Stimulus: rst high 2 cycles, fifo_empty=1, en=1.
   - Required: fifo_rd_en=0, m_valid=0, rd_count=0, proto_err=0 throughout.
2. Single word:
   - Stimulus: FIFO holds 0xA5A5, m_ready=1.
   - Required: fifo_rd_en high exactly 1 cycle; m_valid high 2 cycles later with m_data=0xA5A5 for 1 cycle; rd_count=1; busy low afterwards.
3. Streaming:
   - Stimulus: FIFO preloaded with 8 words 0x0001..0x0008, m_ready=1.
   - Required: 8 consecutive m_valid cycles in order 0x0001..0x0008, no gaps after the first; rd_count=8.
4. Back-pressure:
   - Stimulus: 8 words loaded; m_ready=0 for 5 cycles mid-stream, then 1.
   - Required: at most 2 rd_en issued during the stall; m_data held constant while stalled; no word lost or duplicated; final rd_count=8.
5. en gating:
   - Stimulus: en dropped in the same cycle as a rd_en.
   - Required: that in-flight word is still delivered; no further rd_en while en=0; streaming resumes within 2 cycles of en=1.
6. Reset mid-stream and error flag:
   - Stimulus (reset): rst asserted with occ=2.
   - Required (reset): next cycle m_valid=0, rd_count=0.
   - Stimulus (error): force fifo_underflow=1 the cycle after a rd_en.
   - Required (error): proto_err=1 and it stays high until rst.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues rd_en, captures the
// registered read data into a 2-entry skid buffer and presents it as a valid/ready stream.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy,
    output logic                  proto_err
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] head_q;
    logic [FIFO_WIDTH-1:0] tail_q;
    logic [1:0]            level;
    logic                  push;
    logic                  pop;

    assign push    = inflight;
    assign m_valid = (occ != 2'd0);
    assign m_data  = head_q;
    assign pop     = m_valid && m_ready;
    assign level   = occ + {1'b0, inflight};
    assign busy    = (occ != 2'd0) || inflight;

    // A read may be issued into a full reservation only when a pop frees a slot
    // this same cycle; that keeps occ + inflight <= 2.
    assign fifo_rd_en = !rst && en && !fifo_empty && ((level < 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            rd_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ + {1'b0, push} - {1'b0, pop};

            // Head takes the landing word when it would otherwise be empty,
            // otherwise it shifts up from the tail on a pop.
            if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop)))
                head_q <= fifo_data_out;
            else if (pop)
                head_q <= tail_q;

            if (push && (((occ == 2'd1) && !pop) || (occ == 2'd2)))
                tail_q <= fifo_data_out;

            if (pop)
                rd_count <= rd_count + 1'b1;

            if (inflight && fifo_underflow)
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (occ == 2'd2)));
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model and a
// scoreboard of expected stream words.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  rd_count;
    logic        busy;
    logic        proto_err;

    fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .busy           (busy),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the stimulus, read with one cycle latency.
    logic [15:0] mem [0:255];
    int pushed_cnt = 0;
    int popped_cnt = 0;
    assign fifo_empty = (pushed_cnt == popped_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= mem[popped_cnt[7:0]];
            popped_cnt    <= popped_cnt + 1;
        end
    end

    logic [15:0] exp_q [$];
    logic [3:0]  sb_cnt = '0;
    int          rd_en_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            sb_cnt <= '0;
        end else begin
            if (fifo_rd_en) begin
                rd_en_cnt <= rd_en_cnt + 1;
                check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (m_valid && m_ready) begin
                e = 'x;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                check("stream_data", {16'd0, m_data}, {16'd0, e});
                sb_cnt <= sb_cnt + 1'b1;
            end
        end
    end

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] v);
        mem[pushed_cnt[7:0]] = v;
        pushed_cnt = pushed_cnt + 1;
        exp_q.push_back(v);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) sample();
        check({tag, "_drain_words"}, exp_q.size(), 32'd0);
        check({tag, "_drain_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst = 1'b1; en = 1'b1; m_ready = 1'b1; fifo_underflow = 1'b0;

        // 1. reset then idle
        for (int i = 0; i < 2; i++) begin
            sample();
            check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("rst_m_valid", {31'd0, m_valid}, 32'd0);
            check("rst_m_data", {16'd0, m_data}, 32'd0);
            check("rst_rd_count", {28'd0, rd_count}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        end
        drive_step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("idle_m_valid", {31'd0, m_valid}, 32'd0);
        end
        drive_step(); fifo_underflow = 1'b1;
        drive_step(); fifo_underflow = 1'b0;
        sample();
        check("stray_underflow_ignored", {31'd0, proto_err}, 32'd0);

        // 2. single word
        drive_step(); push_word(16'hA5A5);
        sample();
        check("s2_rd_en_n", {31'd0, fifo_rd_en}, 32'd1);
        drive_step();
        sample();
        check("s2_rd_en_n1", {31'd0, fifo_rd_en}, 32'd0);
        check("s2_valid_n1", {31'd0, m_valid}, 32'd0);
        sample();
        check("s2_valid_n2", {31'd0, m_valid}, 32'd1);
        check("s2_data_n2", {16'd0, m_data}, 32'h0000_A5A5);
        sample();
        check("s2_valid_n3", {31'd0, m_valid}, 32'd0);
        check("s2_busy_after", {31'd0, busy}, 32'd0);
        check("s2_rd_count", {28'd0, rd_count}, 32'd1);

        // 3. streaming of 8 words
        drive_step(); en = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        sample();
        check("s3_en_low_no_rd", {31'd0, fifo_rd_en}, 32'd0);
        drive_step(); en = 1'b1;
        for (int i = 0; i < 20 && !m_valid; i++) sample();
        check("s3_first_valid", {31'd0, m_valid}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("s3_no_gap", {31'd0, m_valid}, 32'd1);
            sample();
        end
        check("s3_end_valid", {31'd0, m_valid}, 32'd0);
        check("s3_rd_count", {28'd0, rd_count}, 32'd9);
        check("s3_rd_count_model", {28'd0, rd_count}, {28'd0, sb_cnt});

        // 4. back-pressure mid-stream
        drive_step();
        for (int i = 0; i < 8; i++) push_word(16'h0040 + 16'(i));
        repeat (4) sample();
        drive_step(); m_ready = 1'b0;
        c0 = rd_en_cnt;
        sample();
        for (int i = 0; i < 5; i++) begin
            check("s4_stall_valid", {31'd0, m_valid}, 32'd1);
            check("s4_stall_hold", {16'd0, m_data}, {16'd0, exp_q[0]});
            if (i < 4) sample();
        end
        check("s4_stall_rd_en_le2", {31'd0, (rd_en_cnt - c0) <= 2}, 32'd1);
        drive_step(); m_ready = 1'b1;
        wait_drain("s4");
        check("s4_rd_count_wrap", {28'd0, rd_count}, 32'd1);
        check("s4_rd_count_model", {28'd0, rd_count}, {28'd0, sb_cnt});

        // 5. en gating with a word in flight
        drive_step();
        for (int i = 0; i < 4; i++) push_word(16'h0050 + 16'(i));
        sample();
        check("s5_rd_en_issued", {31'd0, fifo_rd_en}, 32'd1);
        drive_step(); en = 1'b0;
        c0 = rd_en_cnt;
        sample();
        check("s5_rd_en_gated", {31'd0, fifo_rd_en}, 32'd0);
        repeat (4) sample();
        check("s5_no_rd_while_off", rd_en_cnt - c0, 32'd0);
        check("s5_inflight_delivered", exp_q.size(), 32'd3);
        check("s5_rd_count_mid", {28'd0, rd_count}, 32'd2);
        drive_step(); en = 1'b1;
        sample();
        check("s5_resume", {31'd0, fifo_rd_en}, 32'd1);
        wait_drain("s5");
        check("s5_rd_count", {28'd0, rd_count}, 32'd5);

        // 6a. reset with a full skid buffer
        drive_step(); m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(16'h0060 + 16'(i));
        repeat (4) sample();
        check("s6_full_valid", {31'd0, m_valid}, 32'd1);
        check("s6_full_head", {16'd0, m_data}, {16'd0, exp_q[0]});
        drive_step(); rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(16'h0062);
        sample();
        check("s6_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        drive_step(); rst = 1'b0; m_ready = 1'b1;
        sample();
        check("s6_after_rst_valid", {31'd0, m_valid}, 32'd0);
        check("s6_after_rst_count", {28'd0, rd_count}, 32'd0);
        wait_drain("s6");
        check("s6_rd_count", {28'd0, rd_count}, 32'd1);

        // 6b. underflow one cycle after rd_en
        drive_step(); push_word(16'h0070);
        drive_step(); fifo_underflow = 1'b1;
        drive_step(); fifo_underflow = 1'b0;
        sample();
        check("s6_proto_err_set", {31'd0, proto_err}, 32'd1);
        wait_drain("s6b");
        repeat (3) sample();
        check("s6_proto_err_sticky", {31'd0, proto_err}, 32'd1);
        drive_step(); rst = 1'b1;
        drive_step(); rst = 1'b0;
        sample();
        check("s6_proto_err_cleared", {31'd0, proto_err}, 32'd0);
        check("s6_final_count", {28'd0, rd_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
